mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single unified instruction/data memory port of the multicycle core.
- Requester 0 is the core's memory interface; requester 1 is the program loader / debug DMA port.
- Serializes accesses one at a time, with round-robin fairness.
- Drives the memory-side address, write data and write-enable, and returns a completion pulse and read data to the winning requester.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LAT, 0, memory read latency in cycles (0 = asynchronous read, data valid in the same cycle as the address); legal range 0..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0 write (1) / read (0).
- adr0  in  AW  requester 0 byte address.
- wd0  in  DW  requester 0 write data.
- gnt0  out  1  one-cycle pulse: requester 0 request accepted.
- done0  out  1  one-cycle pulse: requester 0 access complete.
- rdata0  out  DW  read data for requester 0; valid when done0 is high.
- req1, we1, adr1, wd1, gnt1, done1, rdata1: same as above, for requester 1.
- mem_adr  out  AW  address to memory.
- mem_wd  out  DW  write data to memory.
- mem_we  out  1  memory write enable.
- mem_rd  in  DW  read data from memory.
- busy  out  1  high while an access is in progress.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high, port names clk and reset. All outputs are registered.
- Reset values: gnt*, done*, mem_we and busy = 0; mem_adr, mem_wd and rdata* = 0; state = IDLE; priority pointer = requester 0.
- States: IDLE and ACCESS. Only one transaction is ever outstanding.
- IDLE, no request: stay in IDLE; mem_we = 0; mem_adr/mem_wd hold their last value.
- IDLE, request present in cycle T:
  - Select the winner (priority rules below).
  - Latch its adr, we and wd.
  - Move to ACCESS at T+1.
- ACCESS entry (cycle T+1): gnt of the winner = 1 for exactly this cycle; busy = 1.
- ACCESS bus drive: mem_adr/mem_wd are driven from the latched values for the whole ACCESS phase, which lasts LAT+1 cycles (T+1 .. T+1+LAT).
- Writes: mem_we = 1 only in cycle T+1, never repeated.
- Reads: mem_rd is sampled at the end of the final ACCESS cycle (T+1+LAT) into the winner's rdata register.
- Completion (cycle T+2+LAT):
  - Winner's done = 1 for exactly one cycle; state = IDLE; busy = 0.
  - For reads, rdata = the captured data. For writes, rdata is unchanged.
- Back-to-back: the IDLE cycle that carries done may evaluate a new request, so its gnt appears in the following cycle. Per-access throughput is therefore LAT+2 cycles.
- Requester handshake:
  - Hold req, we, adr and wd stable until gnt is seen.
  - Inputs are ignored outside IDLE.
  - A requester that keeps req high after gnt is treated as issuing a new request.
- Priority:
  - Round-robin pointer, initially requester 0.
  - If both requesters are asserting req in IDLE, the requester named by the pointer wins.
  - After any grant, the pointer moves to the other requester.
  - A lone requester always wins, regardless of the pointer.
- Counter: 3-bit latency counter, loaded with 0 on ACCESS entry, incremented each cycle; ACCESS ends when counter == LAT.
- Reset mid-ACCESS: the transaction is aborted immediately.
  - Next cycle is IDLE, with all pulses 0 and mem_we = 0.
  - No done is issued for the aborted access.
- A request that drops during ACCESS does not cancel the transaction; done is still issued.
- gnt0 and gnt1 are never high together; likewise done0 and done1. mem_we is never high outside ACCESS.

Test Plan:
- LAT=0, reset released at cycle 0; req0=1, we0=1, adr0=100, wd0=7 at cycle T → at T+1: gnt0=1, mem_we=1, mem_adr=100, mem_wd=7; at T+2: done0=1, mem_we=0.
- LAT=2; preload mem[96]=0x1234; req1 read adr1=96 at T → gnt1 at T+1; mem_adr=96 for T+1..T+3; at T+4: done1=1, rdata1=0x1234.
- After reset, req0 and req1 both held high with reads → grant order 0,1,0,1; each gnt exactly LAT+2 cycles after the previous one; never two gnts in the same cycle.
- Only req1 active for 3 consecutive requests → gnt1 on every access, no gnt0; the pointer does not starve a lone requester.
- LAT=3, write granted to requester 0, reset asserted during the second ACCESS cycle → next cycle busy=0, mem_we=0, done0 never pulses; a fresh req0 afterwards completes normally.
- req0 dropped immediately after gnt0 on a read → done0 still pulses LAT+1 cycles after gnt0, with correct rdata0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared instruction/data memory port.
// One access is outstanding at a time; every output is registered.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no access in flight; requests are evaluated, done may pulse
// S_ACCESS | bus driven from latched request for LAT+1 cycles
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wd0,
    output logic          gnt0,
    output logic          done0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    output logic          busy
);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    localparam logic [2:0] LAT_C = 3'(LAT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_ptr;
    logic       r_sel;
    logic       r_we;
    logic [2:0] r_cnt;

    logic w_any_req;
    logic w_win;
    logic w_last;
    logic w_load;
    logic w_capture;
    logic w_gnt0_nxt;
    logic w_gnt1_nxt;
    logic w_done0_nxt;
    logic w_done1_nxt;
    logic w_mem_we_nxt;
    logic w_busy_nxt;

    // A lone requester wins outright; the pointer only breaks ties.
    assign w_any_req = req0 | req1;
    assign w_win     = (req0 && req1) ? r_ptr : req1;
    assign w_last    = (r_cnt == LAT_C);
    assign w_load    = (r_state == S_IDLE) && w_any_req;
    assign w_capture = (r_state == S_ACCESS) && w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_last)    w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt0_nxt   = 1'b0;
        w_gnt1_nxt   = 1'b0;
        w_done0_nxt  = 1'b0;
        w_done1_nxt  = 1'b0;
        w_mem_we_nxt = 1'b0;
        w_busy_nxt   = (w_state_nxt == S_ACCESS);
        if (w_load) begin
            w_gnt0_nxt   = !w_win;
            w_gnt1_nxt   = w_win;
            w_mem_we_nxt = w_win ? we1 : we0;
        end
        if (w_capture) begin
            w_done0_nxt = !r_sel;
            w_done1_nxt = r_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            mem_adr <= '0;
            mem_wd  <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
            r_ptr   <= 1'b0;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_cnt   <= 3'd0;
        end else begin
            gnt0   <= w_gnt0_nxt;
            gnt1   <= w_gnt1_nxt;
            done0  <= w_done0_nxt;
            done1  <= w_done1_nxt;
            mem_we <= w_mem_we_nxt;
            busy   <= w_busy_nxt;
            // mem_adr/mem_wd double as the request latch and hold while idle.
            if (w_load) begin
                r_sel   <= w_win;
                r_we    <= w_win ? we1 : we0;
                mem_adr <= w_win ? adr1 : adr0;
                mem_wd  <= w_win ? wd1 : wd0;
                r_ptr   <= !w_win;
                r_cnt   <= 3'd0;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_capture && !r_we) begin
                if (r_sel) begin
                    rdata1 <= mem_rd;
                end else begin
                    rdata0 <= mem_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected grant
// and completion events; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int P   = LAT + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] adr0 = '0, adr1 = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic          gnt0, done0, gnt1, done1, mem_we, busy;
    logic [DW-1:0] rdata0, rdata1, mem_wd, mem_rd;
    logic [AW-1:0] mem_adr;

    logic [31:0] tb_mem [256];

    typedef struct {
        int          id;
        int          cyc;
        logic [31:0] rd;
        bit          chk_rd;
    } exp_t;

    exp_t q_gnt[$];
    exp_t q_done[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   c;

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_rd(mem_rd), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: asynchronous read, preloaded on reset.
    assign mem_rd = tb_mem[mem_adr[7:0]];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 32'h0;
            tb_mem[96]  <= 32'h1234;
            tb_mem[200] <= 32'hBEEF;
        end else if (mem_we) begin
            tb_mem[mem_adr[7:0]] <= mem_wd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int act, input int exp);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_acc(input int id, input int g, input logic [31:0] rd,
                            input bit chk_rd, input bit with_done);
        q_gnt.push_back('{id: id, cyc: g, rd: 32'h0, chk_rd: 1'b0});
        if (with_done) q_done.push_back('{id: id, cyc: g + LAT + 1, rd: rd, chk_rd: chk_rd});
    endtask

    // Monitor: pops expected events whenever the DUT pulses gnt or done.
    always @(negedge clk) begin
        exp_t e;
        if (gnt0 && gnt1) flag("gnt_both_high", 1, 0);
        if (done0 && done1) flag("done_both_high", 1, 0);
        if (mem_we && !busy) flag("mem_we_outside_access", 1, 0);
        while (q_gnt.size() > 0 && q_gnt[0].cyc < cyc) begin
            e = q_gnt.pop_front();
            flag("gnt_missing_cycle", cyc, e.cyc);
        end
        while (q_done.size() > 0 && q_done[0].cyc < cyc) begin
            e = q_done.pop_front();
            flag("done_missing_cycle", cyc, e.cyc);
        end
        if (gnt0 || gnt1) begin
            if (q_gnt.size() == 0) begin
                flag("gnt_unexpected_id", gnt1 ? 1 : 0, -1);
            end else begin
                e = q_gnt.pop_front();
                chk("gnt_id", gnt1 ? 32'd1 : 32'd0, 32'(e.id));
                chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (done0 || done1) begin
            if (q_done.size() == 0) begin
                flag("done_unexpected_id", done1 ? 1 : 0, -1);
            end else begin
                e = q_done.pop_front();
                chk("done_id", done1 ? 32'd1 : 32'd0, 32'(e.id));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                if (e.chk_rd) chk("done_rdata", done1 ? rdata1 : rdata0, e.rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        @(negedge clk);
        chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
        chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
        chk("rst_done0", {31'b0, done0}, 32'd0);
        chk("rst_done1", {31'b0, done1}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_adr", mem_adr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Write from requester 0.
        c = cyc;
        req0 = 1'b1; we0 = 1'b1; adr0 = 100; wd0 = 7;
        push_acc(0, c + 1, 32'h0, 1'b0, 1'b1);
        tick();
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        chk("wr_mem_we_entry", {31'b0, mem_we}, 32'd1);
        chk("wr_mem_adr", mem_adr, 32'd100);
        chk("wr_mem_wd", mem_wd, 32'd7);
        chk("wr_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("wr_mem_we_once", {31'b0, mem_we}, 32'd0);
        repeat (P) tick();
        chk("wr_rdata0_unchanged", rdata0, 32'd0);
        chk("wr_idle_busy", {31'b0, busy}, 32'd0);

        // Read from requester 1; address held for the whole access.
        c = cyc;
        req1 = 1'b1; we1 = 1'b0; adr1 = 96;
        push_acc(1, c + 1, 32'h1234, 1'b1, 1'b1);
        tick();
        req1 = 1'b0;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            chk("rd_mem_adr_hold", mem_adr, 32'd96);
            chk("rd_busy_hold", {31'b0, busy}, 32'd1);
            if (k < LAT) tick();
        end
        tick();
        @(negedge clk);
        chk("rd_rdata1", rdata1, 32'h1234);
        chk("rd_done_busy", {31'b0, busy}, 32'd0);
        tick();

        // Read back the earlier write.
        c = cyc;
        req0 = 1'b1; we0 = 1'b0; adr0 = 100;
        push_acc(0, c + 1, 32'd7, 1'b1, 1'b1);
        tick();
        req0 = 1'b0;
        repeat (P) tick();

        // Round robin from reset with both requesters held high.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        c = cyc;
        req0 = 1'b1; we0 = 1'b0; adr0 = 96;
        req1 = 1'b1; we1 = 1'b0; adr1 = 200;
        push_acc(0, c + 1,         32'h1234, 1'b1, 1'b1);
        push_acc(1, c + 1 + P,     32'hBEEF, 1'b1, 1'b1);
        push_acc(0, c + 1 + 2 * P, 32'h1234, 1'b1, 1'b1);
        push_acc(1, c + 1 + 3 * P, 32'hBEEF, 1'b1, 1'b1);
        repeat (1 + 3 * P) tick();
        req0 = 1'b0; req1 = 1'b0;
        repeat (P) tick();

        // Lone requester 1 back to back, pointer favouring requester 0.
        c = cyc;
        req1 = 1'b1; we1 = 1'b0; adr1 = 96;
        for (int k = 0; k < 3; k++) push_acc(1, c + 1 + k * P, 32'h1234, 1'b1, 1'b1);
        repeat (1 + 2 * P) tick();
        req1 = 1'b0;
        repeat (P) tick();

        // Reset in the second access cycle of a write aborts it without done.
        c = cyc;
        req0 = 1'b1; we0 = 1'b1; adr0 = 50; wd0 = 32'h55;
        push_acc(0, c + 1, 32'h0, 1'b0, 1'b0);
        tick();
        req0 = 1'b0; we0 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_mem_we", {31'b0, mem_we}, 32'd0);
        chk("abort_done0", {31'b0, done0}, 32'd0);
        chk("abort_gnt0", {31'b0, gnt0}, 32'd0);
        repeat (P + 2) tick();

        // Fresh read after abort; request dropped right after its grant.
        c = cyc;
        req0 = 1'b1; we0 = 1'b0; adr0 = 200;
        push_acc(0, c + 1, 32'hBEEF, 1'b1, 1'b1);
        tick();
        req0 = 1'b0;
        repeat (P) tick();

        for (int k = 0; k < 20 && (q_gnt.size() > 0 || q_done.size() > 0); k++) tick();
        if (q_gnt.size() > 0) flag("gnt_left_pending", q_gnt.size(), 0);
        if (q_done.size() > 0) flag("done_left_pending", q_done.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
